stack_arbiter: RTL and testbench

Round-robin arbiter that shares one `stack` instance between two requesters, A and B. Each requester issues push or pop requests over a req/ack handshake. The arbiter serialises requests, drives the stack's single-cycle `push`/`pop` strobes, and returns pop data. It also blocks illegal operations: push when full, pop when empty. It sits between the two client blocks and the stack, and it is the stack's only driver.

---
 rtl/stack_arbiter_if.sv | 35 +++
 rtl/stack_arbiter.sv | 165 ++++++++++++++++
 tb/tb_stack_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// Bundle of client handshakes and stack-side signals for stack_arbiter.
// err_a/err_b exist only when STACK_ARB_ERR_EN is defined.
interface stack_arbiter_if #(parameter int DW = 8);
    logic          req_a, req_b;
    logic          op_a, op_b;
    logic [DW-1:0] din_a, din_b;
    logic          ack_a, ack_b;
    logic [DW-1:0] rdata_a, rdata_b;
`ifdef STACK_ARB_ERR_EN
    logic          err_a, err_b;
`endif
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_d_in, stk_d_out;
    logic          stk_full, stk_empty;

`ifdef STACK_ARB_ERR_EN
    modport slave (
        input  req_a, req_b, op_a, op_b, din_a, din_b, stk_d_out, stk_full, stk_empty,
        output ack_a, ack_b, rdata_a, rdata_b, err_a, err_b, stk_push, stk_pop, stk_d_in
    );
    modport master (
        output req_a, req_b, op_a, op_b, din_a, din_b, stk_d_out, stk_full, stk_empty,
        input  ack_a, ack_b, rdata_a, rdata_b, err_a, err_b, stk_push, stk_pop, stk_d_in
    );
`else
    modport slave (
        input  req_a, req_b, op_a, op_b, din_a, din_b, stk_d_out, stk_full, stk_empty,
        output ack_a, ack_b, rdata_a, rdata_b, stk_push, stk_pop, stk_d_in
    );
    modport master (
        output req_a, req_b, op_a, op_b, din_a, din_b, stk_d_out, stk_full, stk_empty,
        input  ack_a, ack_b, rdata_a, rdata_b, stk_push, stk_pop, stk_d_in
    );
`endif
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between requesters A and B.
// Define STACK_ARB_ERR_EN to complete illegal ops with err instead of stalling them.
module stack_arbiter #(
    parameter int data_bus_width    = 8,
    parameter int address_bus_width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    stack_arbiter_if.slave   bus
);
    if (data_bus_width < 1 || address_bus_width < 1) begin : g_bad_width
        $error("stack_arbiter: bus widths must be positive");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_rr, w_rr_nxt;
    logic                      r_id, w_id_nxt;
    logic                      r_op, w_op_nxt;
    logic                      r_push, w_push_nxt;
    logic                      r_pop, w_pop_nxt;
    logic                      r_ack_a, w_ack_a_nxt;
    logic                      r_ack_b, w_ack_b_nxt;
    logic [data_bus_width-1:0] r_d_in, w_d_in_nxt;
    logic [data_bus_width-1:0] r_rdata_a, w_rdata_a_nxt;
    logic [data_bus_width-1:0] r_rdata_b, w_rdata_b_nxt;
`ifdef STACK_ARB_ERR_EN
    logic                      r_err_a, w_err_a_nxt;
    logic                      r_err_b, w_err_b_nxt;
    logic                      w_win_ill;
`endif
    logic                      w_ill_a, w_ill_b;
    logic                      w_elig_a, w_elig_b;
    logic                      w_win, w_win_op;
    logic [data_bus_width-1:0] w_win_din;

    assign w_ill_a = bus.op_a ? bus.stk_full : bus.stk_empty;
    assign w_ill_b = bus.op_b ? bus.stk_full : bus.stk_empty;

`ifdef STACK_ARB_ERR_EN
    assign w_elig_a  = bus.req_a;
    assign w_elig_b  = bus.req_b;
    assign w_win_ill = w_win ? w_ill_b : w_ill_a;
`else
    // Illegal requests simply wait; the other port keeps being served.
    assign w_elig_a  = bus.req_a & ~w_ill_a;
    assign w_elig_b  = bus.req_b & ~w_ill_b;
`endif

    // w_win: 0 = A, 1 = B; r_rr names the preferred port on a tie.
    assign w_win     = (w_elig_a & w_elig_b) ? r_rr : w_elig_b;
    assign w_win_op  = w_win ? bus.op_b  : bus.op_a;
    assign w_win_din = w_win ? bus.din_b : bus.din_a;

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_id_nxt      = r_id;
        w_op_nxt      = r_op;
        w_d_in_nxt    = r_d_in;
        w_rdata_a_nxt = r_rdata_a;
        w_rdata_b_nxt = r_rdata_b;
        w_push_nxt    = 1'b0;
        w_pop_nxt     = 1'b0;
        w_ack_a_nxt   = 1'b0;
        w_ack_b_nxt   = 1'b0;
`ifdef STACK_ARB_ERR_EN
        w_err_a_nxt   = 1'b0;
        w_err_b_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_elig_a | w_elig_b) begin
                    w_id_nxt   = w_win;
                    w_op_nxt   = w_win_op;
                    w_rr_nxt   = ~w_win;
                    w_d_in_nxt = w_win_din;
`ifdef STACK_ARB_ERR_EN
                    if (w_win_ill) begin
                        w_state_nxt = DONE;
                        w_ack_a_nxt = ~w_win;
                        w_ack_b_nxt = w_win;
                        w_err_a_nxt = ~w_win;
                        w_err_b_nxt = w_win;
                    end else begin
`else
                    begin
`endif
                        w_state_nxt = ISSUE;
                        w_push_nxt  = w_win_op;
                        w_pop_nxt   = ~w_win_op;
                    end
                end
            end
            ISSUE: begin
                if (r_op) begin
                    w_state_nxt = DONE;
                    w_ack_a_nxt = ~r_id;
                    w_ack_b_nxt = r_id;
                end else begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // stk_d_out settled on the edge that closed the pop strobe
                if (r_id) w_rdata_b_nxt = bus.stk_d_out;
                else      w_rdata_a_nxt = bus.stk_d_out;
                w_state_nxt = DONE;
                w_ack_a_nxt = ~r_id;
                w_ack_b_nxt = r_id;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr      <= 1'b0;
            r_id      <= 1'b0;
            r_op      <= 1'b0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_d_in    <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
`ifdef STACK_ARB_ERR_EN
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_id      <= w_id_nxt;
            r_op      <= w_op_nxt;
            r_push    <= w_push_nxt;
            r_pop     <= w_pop_nxt;
            r_ack_a   <= w_ack_a_nxt;
            r_ack_b   <= w_ack_b_nxt;
            r_d_in    <= w_d_in_nxt;
            r_rdata_a <= w_rdata_a_nxt;
            r_rdata_b <= w_rdata_b_nxt;
`ifdef STACK_ARB_ERR_EN
            r_err_a   <= w_err_a_nxt;
            r_err_b   <= w_err_b_nxt;
`endif
        end
    end

    assign bus.ack_a    = r_ack_a;
    assign bus.ack_b    = r_ack_b;
    assign bus.rdata_a  = r_rdata_a;
    assign bus.rdata_b  = r_rdata_b;
    assign bus.stk_push = r_push;
    assign bus.stk_pop  = r_pop;
    assign bus.stk_d_in = r_d_in;
`ifdef STACK_ARB_ERR_EN
    assign bus.err_a    = r_err_a;
    assign bus.err_b    = r_err_b;
`endif
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack, transaction-level model, scoreboard.
module tb_stack_arbiter;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_arbiter_if #(.DW(DW)) bus();
    stack_arbiter #(.data_bus_width(DW), .address_bus_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Environment stack: full at DEPTH entries, read data one edge after pop.
    logic [DW-1:0] smem [0:DEPTH];
    int            sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0;
            bus.stk_d_out <= '0;
        end else if (bus.stk_push && sp < DEPTH) begin
            smem[sp] <= bus.stk_d_in;
            sp <= sp + 1;
        end else if (bus.stk_pop && sp > 0) begin
            bus.stk_d_out <= smem[sp-1];
            sp <= sp - 1;
        end
    end
    assign bus.stk_full  = (sp == DEPTH);
    assign bus.stk_empty = (sp == 0);

    typedef struct { int port; int cyc; logic is_pop; logic [DW-1:0] data; logic err; } ack_t;
    typedef struct { int cyc; logic is_push; logic [DW-1:0] data; } stb_t;
    ack_t ackq[$];
    stb_t stbq[$];
    logic [DW-1:0] mstk[$];
    int tests = 0, fails = 0, cyc = 0;

    // Reference model: decides grants from the request rules and a queue-based stack,
    // and predicts the cycle of each strobe and ack from the fixed op latencies.
    initial begin : model
        int next_ok, pref, w;
        logic ea, eb, la, lb, op, legal;
        logic [DW-1:0] d, pd;
        next_ok = 0; pref = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ackq.delete(); stbq.delete(); mstk.delete();
                next_ok = 0; pref = 0;
            end else begin
                cyc++;
                if (cyc >= next_ok) begin
                    la = bus.op_a ? (mstk.size() < DEPTH) : (mstk.size() > 0);
                    lb = bus.op_b ? (mstk.size() < DEPTH) : (mstk.size() > 0);
`ifdef STACK_ARB_ERR_EN
                    ea = bus.req_a; eb = bus.req_b;
`else
                    ea = bus.req_a && la; eb = bus.req_b && lb;
`endif
                    if (ea || eb) begin
                        w = (ea && eb) ? pref : (eb ? 1 : 0);
                        pref = 1 - w;
                        op    = w ? bus.op_b  : bus.op_a;
                        d     = w ? bus.din_b : bus.din_a;
                        legal = w ? lb : la;
                        if (!legal) begin
                            ackq.push_back('{w, cyc, 1'b0, '0, 1'b1});
                            next_ok = cyc + 2;
                        end else if (op) begin
                            mstk.push_back(d);
                            stbq.push_back('{cyc, 1'b1, d});
                            ackq.push_back('{w, cyc + 1, 1'b0, '0, 1'b0});
                            next_ok = cyc + 3;
                        end else begin
                            pd = mstk.pop_back();
                            stbq.push_back('{cyc, 1'b0, '0});
                            ackq.push_back('{w, cyc + 2, 1'b1, pd, 1'b0});
                            next_ok = cyc + 4;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every strobe and ack against the model's predictions.
    initial begin : monitor
        stb_t s;
        ack_t a;
        int gp;
        logic ge;
        logic [DW-1:0] gd;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.stk_push || bus.stk_pop) begin
                    tests++;
                    if (stbq.size() == 0) begin
                        fails++;
                        $display("FAIL strobe: unexpected push=%0b pop=%0b at cycle %0d, required none", bus.stk_push, bus.stk_pop, cyc);
                    end else begin
                        s = stbq.pop_front();
                        if (s.cyc != cyc || (bus.stk_push && bus.stk_pop) || bus.stk_push != s.is_push ||
                            (s.is_push && bus.stk_d_in != s.data)) begin
                            fails++;
                            $display("FAIL strobe: got push=%0b pop=%0b d_in=%h cycle %0d, required push=%0b d_in=%h cycle %0d",
                                     bus.stk_push, bus.stk_pop, bus.stk_d_in, cyc, s.is_push, s.data, s.cyc);
                        end
                    end
                end else if (stbq.size() > 0 && stbq[0].cyc <= cyc) begin
                    tests++; fails++;
                    s = stbq.pop_front();
                    $display("FAIL strobe: missing push=%0b strobe, required in cycle %0d", s.is_push, s.cyc);
                end
                if (bus.ack_a || bus.ack_b) begin
                    tests++;
                    gp = bus.ack_b ? 1 : 0;
                    gd = gp ? bus.rdata_b : bus.rdata_a;
`ifdef STACK_ARB_ERR_EN
                    ge = gp ? bus.err_b : bus.err_a;
`else
                    ge = 1'b0;
`endif
                    if (ackq.size() == 0) begin
                        fails++;
                        $display("FAIL ack: unexpected ack port %0d at cycle %0d, required none", gp, cyc);
                    end else begin
                        a = ackq.pop_front();
                        if ((bus.ack_a && bus.ack_b) || a.port != gp || a.cyc != cyc || a.err != ge ||
                            (a.is_pop && gd != a.data)) begin
                            fails++;
                            $display("FAIL ack: got port %0d cycle %0d rdata %h err %0b, required port %0d cycle %0d rdata %h err %0b",
                                     gp, cyc, gd, ge, a.port, a.cyc, a.data, a.err);
                        end
                    end
                end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
                    tests++; fails++;
                    a = ackq.pop_front();
                    $display("FAIL ack: missing ack port %0d, required in cycle %0d", a.port, a.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic op, input logic [DW-1:0] d);
        if (p == 0) begin bus.req_a = r; bus.op_a = op; bus.din_a = d; end
        else        begin bus.req_b = r; bus.op_b = op; bus.din_b = d; end
    endtask

    // Issues one request aligned just after a rising edge; returns aligned just after
    // the edge that ends the ack cycle, with req dropped.
    task automatic do_op(input int p, input logic op, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output int acyc);
        bit got = 0;
        rd = '0; acyc = -1;
        set_req(p, 1'b1, op, d);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (p == 0 ? bus.ack_a : bus.ack_b) begin
                got = 1;
                rd = (p == 0) ? bus.rdata_a : bus.rdata_b;
                acyc = cyc;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL timeout: port %0d op %0b got no ack, required ack within 400 cycles", p, op);
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, '0);
    endtask

    task automatic push_burst(input int p, input int n, input logic [DW-1:0] base);
        logic [DW-1:0] rd; int ac;
        for (int i = 0; i < n; i++) do_op(p, 1'b1, base + DW'(i), rd, ac);
    endtask

    // mode 0 = push only, 1 = pop only, 2 = random op
    task automatic run_port(input int p, input int n, input int mode);
        logic [DW-1:0] rd; int ac; logic op;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            op = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
            do_op(p, op, DW'($urandom), rd, ac);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] rd, rd_b;
        int ac_a, ac_b;
        set_req(0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {bus.ack_a, bus.ack_b, bus.stk_push, bus.stk_pop,
                                bus.stk_d_in, bus.rdata_a, bus.rdata_b}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 1'b1, 8'h5A, rd, ac_a);
        do_op(1, 1'b0, '0, rd, ac_b);
        check("pop_5A", rd, 8'h5A);

        for (int i = 1; i <= 3; i++) do_op(0, 1'b1, DW'(i), rd, ac_a);
        for (int i = 3; i >= 1; i--) begin
            do_op(1, 1'b0, '0, rd, ac_b);
            check("lifo_pop", rd, 64'(i));
        end
        check("lifo_empty", bus.stk_empty, 1);

        // Reset while the arbiter sits in CAPTURE for B's pop.
        do_op(0, 1'b1, 8'h33, rd, ac_a);
        set_req(1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 20 && !bus.stk_pop; i++) @(negedge clk);
        check("reset_pop_seen", bus.stk_pop, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        set_req(1, 1'b0, 1'b0, '0);
        check("reset_mid_capture", {bus.ack_a, bus.ack_b, bus.stk_push, bus.stk_pop,
                                    bus.stk_d_in, bus.rdata_a, bus.rdata_b}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        fork
            push_burst(0, 8, 8'hA0);
            push_burst(1, 7, 8'hB0);
        join
        for (int i = 0; i < DEPTH; i++)
            check("fill_order", smem[i], 64'((i % 2 == 0) ? (8'hA0 + i / 2) : (8'hB0 + i / 2)));
        check("fill_full", bus.stk_full, 1);

`ifdef STACK_ARB_ERR_EN
        do_op(0, 1'b1, 8'h77, rd, ac_a);
        check("full_push_count", sp, DEPTH);
        check("full_push_top", smem[DEPTH-1], 8'hA7);
        do_reset();
        do_op(1, 1'b0, '0, rd, ac_b);
        check("empty_pop_count", sp, 0);
`else
        fork
            do_op(0, 1'b1, 8'h77, rd, ac_a);
            do_op(1, 1'b0, '0, rd_b, ac_b);
        join
        check("full_b_first", ac_b < ac_a, 1);
        check("full_b_data", rd_b, 8'hA7);
        check("full_a_top", smem[DEPTH-1], 8'h77);
`endif

        do_reset();
        fork
`ifdef STACK_ARB_ERR_EN
            run_port(0, 40, 2);
            run_port(1, 40, 2);
`else
            run_port(0, 40, 0);
            run_port(1, 40, 1);
`endif
        join
        repeat (6) @(posedge clk); #1;
        check("drain_acks", ackq.size(), 0);
        check("drain_strobes", stbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
